// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, default timing
// constants and small column-decode helpers.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  localparam int unsigned TICK_DIV_DEFAULT  = 50000;
  localparam int unsigned DEB_TICKS_DEFAULT = 8;

  // True when exactly one column line is pulled low.
  function automatic logic single_low(input logic [3:0] c);
    case (c)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] c);
    case (c)
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running divider producing a one-clock tick every DIV clock cycles.
module scan_tick #(
  parameter int unsigned DIV = 50000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn)            cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: row strobing, debounce, single-key acceptance and an
// 8-digit shift register of accepted key codes.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
  parameter int unsigned DEB_TICKS = DEB_TICKS_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [3:0]  col,
  input  logic        clr,
  output logic [3:0]  row,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [31:0] num
);

  localparam int unsigned CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS);

  logic          tick;
  logic [3:0]    col_m, col_s;
  state_t        state, state_n;
  logic [1:0]    ridx, ridx_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]    col_lat, col_lat_n;
  logic          accept;
  logic [3:0]    code_new;

  scan_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      col_m <= '1;
      col_s <= '1;
    end else begin
      col_m <= col;
      col_s <= col_m;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= SCAN;
      ridx    <= '0;
      cnt     <= '0;
      col_lat <= '1;
    end else begin
      state   <= state_n;
      ridx    <= ridx_n;
      cnt     <= cnt_n;
      col_lat <= col_lat_n;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n   = state;
    ridx_n    = ridx;
    cnt_n     = cnt;
    col_lat_n = col_lat;
    accept    = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (single_low(col_s)) begin
            col_lat_n = col_s;
            cnt_n     = CW'(1);
            state_n   = DEBOUNCE;
          end else begin
            ridx_n = ridx + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (col_s == col_lat) begin
            if (cnt_inc == DEB_LAST) begin
              state_n = HOLD;
              cnt_n   = '0;
              accept  = 1'b1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = SCAN;
            cnt_n   = '0;
          end
        end
        HOLD: begin
          if (col_s == 4'hF) begin
            if (cnt_inc == DEB_LAST) begin
              state_n = SCAN;
              ridx_n  = ridx + 1'b1;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          state_n = SCAN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    row      = ~(4'b0001 << ridx);
    code_new = {ridx, low_index(col_lat)};
  end

  // clr wins over the shift, but the key itself is still reported.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      key_valid <= 1'b0;
      key_code  <= '0;
      num       <= '0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= code_new;
      if (clr)         num <= '0;
      else if (accept) num <= {num[27:0], code_new};
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with TICK_DIV=4, DEB_TICKS=3 and a simple
// keypad model that pulls a column low while its row is driven.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  col;
  logic        clr;
  logic [3:0]  row;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] num;

  logic        key_on;
  logic [1:0]  kr, kc;
  logic        force_en;
  logic [3:0]  force_val;
  logic [3:0]  model_col;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned pulses = 0;

  keypad_scan #(.TICK_DIV(4), .DEB_TICKS(3)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .col       (col),
    .clr       (clr),
    .row       (row),
    .key_valid (key_valid),
    .key_code  (key_code),
    .num       (num)
  );

  always #5 clk = ~clk;

  always_comb begin
    model_col = 4'hF;
    if (key_on && row == ~(4'b0001 << kr)) model_col = ~(4'b0001 << kc);
  end
  assign col = force_en ? force_val : model_col;

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Assert reset for one edge, check reset outputs, optionally drop the key.
  task automatic pulse_reset(input string tag, input bit drop_key);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_row"}, row, 4'b1110);
    check({tag, "_valid"}, key_valid, 1'b0);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_num"}, num, 32'h0);
    if (drop_key) key_on = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Called right after reset release at a negedge: row steps every 4 clocks.
  task automatic check_scan(input string tag);
    int unsigned p0;
    logic [3:0] exp_row;
    p0 = pulses;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i % 4 == 2) begin
        exp_row = ~(4'b0001 << ((i / 4) % 4));
        check({tag, "_row"}, row, exp_row);
      end
    end
    check({tag, "_nopulse"}, pulses - p0, 0);
  endtask

  task automatic wait_valid(input int unsigned budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (key_valid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic press_release(input string tag, input logic [3:0] code, input bit with_clr);
    bit found;
    int unsigned p0;
    p0 = pulses;
    kr = code[3:2];
    kc = code[1:0];
    clr = with_clr;
    key_on = 1'b1;
    wait_valid(80, found);
    check({tag, "_seen"}, found, 1'b1);
    check({tag, "_code"}, key_code, code);
    clr = 1'b0;
    repeat (40) @(negedge clk);
    key_on = 1'b0;
    repeat (30) @(negedge clk);
    check({tag, "_once"}, pulses - p0, 1);
  endtask

  initial begin
    bit found;
    int unsigned p0;
    rstn = 1'b0; clr = 1'b0; key_on = 1'b0; kr = '0; kc = '0;
    force_en = 1'b0; force_val = 4'hF;

    pulse_reset("rst", 1'b0);
    check_scan("idle");
    check("idle_num", num, 32'h0);

    // Row 2, column 1 -> code 9, held long: exactly one pulse.
    press_release("k9", 4'h9, 1'b0);
    check("k9_num", num, 32'h0000_0009);

    for (int d = 1; d <= 8; d++) press_release("seq", 4'(d), 1'b0);
    check("seq8_num", num, 32'h1234_5678);
    press_release("seq9", 4'h9, 1'b0);
    check("seq9_num", num, 32'h2345_6789);

    // Bounce: line low for two ticks only, FSM must fall back onto the same row.
    p0 = pulses;
    for (int i = 0; i < 40 && row == 4'b1101; i++) @(negedge clk);
    for (int i = 0; i < 40 && row != 4'b1101; i++) @(negedge clk);
    check("bnc_align", row, 4'b1101);
    force_val = 4'b1110;
    force_en = 1'b1;
    repeat (8) @(negedge clk);
    check("bnc_hold_row", row, 4'b1101);
    force_en = 1'b0;
    repeat (4) @(negedge clk);
    check("bnc_same_row", row, 4'b1101);
    repeat (4) @(negedge clk);
    check("bnc_resume_row", row, 4'b1011);
    check("bnc_nopulse", pulses - p0, 0);

    // Two columns low at once is rejected.
    p0 = pulses;
    force_val = 4'b1100;
    force_en = 1'b1;
    repeat (60) @(negedge clk);
    force_en = 1'b0;
    repeat (10) @(negedge clk);
    check("multi_nopulse", pulses - p0, 0);
    check("multi_num", num, 32'h2345_6789);

    // clr held across the accepting edge of key A.
    press_release("clrA", 4'hA, 1'b1);
    check("clrA_num", num, 32'h0);
    press_release("k5", 4'h5, 1'b0);
    check("k5_num", num, 32'h0000_0005);

    // Reset in HOLD, key released during reset: clean restart, no pulse.
    kr = 2'd1; kc = 2'd2; key_on = 1'b1;
    wait_valid(80, found);
    check("k6_seen", found, 1'b1);
    repeat (5) @(negedge clk);
    pulse_reset("rst_hold", 1'b1);
    check_scan("after_rst");
    press_release("k6", 4'h6, 1'b0);
    check("k6_num", num, 32'h0000_0006);

    // Reset in HOLD with key still held: the key is detected again.
    kr = 2'd0; kc = 2'd3; key_on = 1'b1;
    wait_valid(80, found);
    check("k3_seen", found, 1'b1);
    repeat (5) @(negedge clk);
    pulse_reset("rst_held", 1'b0);
    wait_valid(80, found);
    check("k3_redetect", found, 1'b1);
    check("k3_code", key_code, 4'h3);
    check("k3_num", num, 32'h0000_0003);
    key_on = 1'b0;
    repeat (30) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
